// File: rtl/priority_arbiter_pkg.sv
// Shared types and constants for the priority arbiter and its bus interface.
package priority_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_arbiter_if.sv
// Requester-side bus of the priority arbiter, plus the FSM state for observation.
interface priority_arbiter_if
  import priority_arbiter_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  // Handshake: a requester holds req[i] high until it is granted (v=1, y=i) and
  // keeps it high while it uses the resource; it releases by pulsing done or by
  // dropping req[i]. The grant is held, unchanged, until that release is sampled.
  logic [N-1:0] req;
  logic         done;
  logic         rr_en;
  logic [W-1:0] y;
  logic         v;
  logic [N-1:0] gnt;
  state_t       state;

  modport master (output req, done, rr_en, input y, v, gnt, state);
  modport slave  (input req, done, rr_en, output y, v, gnt, state);

endinterface

// File: rtl/priority_arbiter_pick.sv
// Combinational descending search over req starting at 'start', wrapping N-1 after 0.
module priority_pick #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) - k;
      if (j < 0) j = j + N;
      if (req[W'(j)]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: fixed or round-robin pick, grant held until release.
module priority_arbiter
  import priority_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst_n,
  priority_arbiter_if.slave bus
);

  localparam int W = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] last_q, last_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic         v_q, v_d;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] idx;

  // Round-robin begins one below the last holder; last = 0 makes it start at N-1.
  assign start = (bus.rr_en == MODE_FIXED) ? W'(N - 1)
               : (last_q == '0)            ? W'(N - 1)
               :                             last_q - W'(1);

  priority_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .start (start),
    .found (found),
    .idx   (idx)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          y_d     = idx;
          v_d     = 1'b1;
          gnt_d   = ONE << idx;
        end
      end
      GRANT: begin
        if (bus.done || !bus.req[y_q]) begin
          state_d = IDLE;
          y_d     = '0;
          v_d     = 1'b0;
          gnt_d   = '0;
          last_d  = y_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      v_q     <= 1'b0;
      gnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.v     = v_q;
  assign bus.gnt   = gnt_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: directed scenarios on N=4 and N=8 plus randomized N=4 traffic.
module tb_priority_arbiter;
  import priority_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  priority_arbiter_if #(.N(4)) if4 ();
  priority_arbiter_if #(.N(8)) if8 ();

  priority_arbiter #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  priority_arbiter #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  int checks = 0;
  int errors = 0;

  // Reference model of the N=4 arbiter: granted flag, holder, last holder.
  bit m_v;
  int m_y;
  int m_last;
  logic [6:0] exp_q[$];

  // Winner = set index at the smallest descending distance from the start point.
  function automatic int ref_pick(int n, logic [7:0] r, bit rr, int last);
    int start, best, best_d, d;
    start  = rr ? (last + n - 1) % n : n - 1;
    best   = -1;
    best_d = n;
    for (int i = 0; i < n; i++) begin
      d = (start - i + n) % n;
      if (r[i] && d < best_d) begin
        best   = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic logic [6:0] exp4();
    logic [1:0] yy;
    logic [3:0] g;
    yy = m_y[1:0];
    g  = m_v ? (4'b0001 << yy) : 4'b0000;
    return {m_v, yy, g};
  endfunction

  // Advance the model using the inputs the DUT sees at this edge, then step one cycle.
  task automatic advance4();
    int w;
    if (!m_v) begin
      w = ref_pick(4, {4'b0000, if4.req}, if4.rr_en, m_last);
      if (w >= 0) begin
        m_v = 1'b1;
        m_y = w;
      end
    end else if (if4.done || !if4.req[m_y]) begin
      m_last = m_y;
      m_v    = 1'b0;
      m_y    = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    if4.req   = '0;
    if4.done  = 1'b0;
    if4.rr_en = MODE_FIXED;
    if8.req   = '0;
    if8.done  = 1'b0;
    if8.rr_en = MODE_FIXED;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_v    = 1'b0;
    m_y    = 0;
    m_last = 0;
  endtask

  task automatic test_reset();
    #1;
    rst_n     = 1'b0;
    if4.req   = 4'b1111;
    if4.done  = 1'b0;
    if4.rr_en = MODE_FIXED;
    if8.req   = '0;
    if8.done  = 1'b0;
    if8.rr_en = MODE_FIXED;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({if4.v, if4.y, if4.gnt} !== 7'b0 || if4.state !== IDLE) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d v=%b y=%0d gnt=%b state=%0d expected v=0 y=0 gnt=0000 IDLE",
                 c, if4.v, if4.y, if4.gnt, if4.state);
      end
    end
    rst_n  = 1'b1;
    m_v    = 1'b0;
    m_y    = 0;
    m_last = 0;
    advance4();
    checks++;
    if (if4.v !== 1'b1 || if4.y !== 2'd3 || if4.gnt !== 4'b1000 || if4.state !== GRANT) begin
      errors++;
      $display("FAIL reset_first_grant v=%b y=%0d gnt=%b expected v=1 y=3 gnt=1000", if4.v, if4.y, if4.gnt);
    end
  endtask

  task automatic test_fixed_hold();
    do_reset();
    if4.req = 4'b0110;
    advance4();
    checks++;
    if (if4.v !== 1'b1 || if4.y !== 2'd2 || {if4.v, if4.y, if4.gnt} !== exp4()) begin
      errors++;
      $display("FAIL fixed_grant v=%b y=%0d gnt=%b expected v=1 y=2 gnt=0100", if4.v, if4.y, if4.gnt);
    end
    if4.req = 4'b1110;
    advance4();
    checks++;
    if (if4.y !== 2'd2 || if4.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL fixed_hold y=%0d gnt=%b expected y=2 gnt=0100", if4.y, if4.gnt);
    end
    if4.done = 1'b1;
    advance4();
    if4.done = 1'b0;
    checks++;
    if ({if4.v, if4.y, if4.gnt} !== 7'b0) begin
      errors++;
      $display("FAIL fixed_release v=%b y=%0d gnt=%b expected all zero", if4.v, if4.y, if4.gnt);
    end
    advance4();
    checks++;
    if (if4.v !== 1'b1 || if4.y !== 2'd3 || if4.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL fixed_regrant v=%b y=%0d gnt=%b expected v=1 y=3 gnt=1000", if4.v, if4.y, if4.gnt);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[5];
    exp_seq = '{3, 2, 1, 0, 3};
    do_reset();
    if4.rr_en = MODE_RR;
    if4.req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      advance4();
      checks++;
      if (if4.v !== 1'b1 || int'(if4.y) != exp_seq[g] || {if4.v, if4.y, if4.gnt} !== exp4()) begin
        errors++;
        $display("FAIL rr_grant idx=%0d v=%b y=%0d expected v=1 y=%0d", g, if4.v, if4.y, exp_seq[g]);
      end
      if4.done = 1'b1;
      advance4();
      if4.done = 1'b0;
      checks++;
      if (if4.v !== 1'b0 || if4.gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_idle idx=%0d v=%b gnt=%b expected v=0 gnt=0000", g, if4.v, if4.gnt);
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    if4.req = 4'b0010;
    advance4();
    checks++;
    if (if4.v !== 1'b1 || if4.y !== 2'd1) begin
      errors++;
      $display("FAIL drop_grant v=%b y=%0d expected v=1 y=1", if4.v, if4.y);
    end
    if4.req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      advance4();
      checks++;
      if ({if4.v, if4.y, if4.gnt} !== 7'b0) begin
        errors++;
        $display("FAIL drop_release cyc=%0d v=%b y=%0d gnt=%b expected all zero", c, if4.v, if4.y, if4.gnt);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    if4.rr_en = MODE_RR;
    if4.req   = 4'b1111;
    for (int g = 0; g < 2; g++) begin
      advance4();
      if4.done = 1'b1;
      advance4();
      if4.done = 1'b0;
    end
    advance4();
    checks++;
    if (if4.v !== 1'b1 || if4.y !== 2'd1) begin
      errors++;
      $display("FAIL async_pre v=%b y=%0d expected v=1 y=1", if4.v, if4.y);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({if4.v, if4.y, if4.gnt} !== 7'b0) begin
      errors++;
      $display("FAIL async_clear v=%b y=%0d gnt=%b expected all zero before edge", if4.v, if4.y, if4.gnt);
    end
    #1 rst_n = 1'b1;
    m_v    = 1'b0;
    m_y    = 0;
    m_last = 0;
    advance4();
    checks++;
    if (if4.v !== 1'b1 || if4.y !== 2'd3 || if4.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL async_after v=%b y=%0d gnt=%b expected v=1 y=3 gnt=1000", if4.v, if4.y, if4.gnt);
    end
  endtask

  task automatic test_width();
    do_reset();
    if8.rr_en = MODE_FIXED;
    if8.req   = 8'b1000_0001;
    @(posedge clk);
    #1;
    checks++;
    if (if8.v !== 1'b1 || if8.y !== 3'd7 || if8.gnt !== 8'h80) begin
      errors++;
      $display("FAIL width_high v=%b y=%0d gnt=%h expected v=1 y=7 gnt=80", if8.v, if8.y, if8.gnt);
    end
    if8.done = 1'b1;
    if8.req  = 8'h01;
    @(posedge clk);
    #1;
    if8.done = 1'b0;
    checks++;
    if (if8.v !== 1'b0 || if8.gnt !== 8'h00) begin
      errors++;
      $display("FAIL width_release v=%b gnt=%h expected v=0 gnt=00", if8.v, if8.gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if8.v !== 1'b1 || if8.y !== 3'd0 || if8.gnt !== 8'h01) begin
      errors++;
      $display("FAIL width_low v=%b y=%0d gnt=%h expected v=1 y=0 gnt=01", if8.v, if8.y, if8.gnt);
    end
  endtask

  task automatic test_random();
    logic [6:0] exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) if4.req = 4'($urandom_range(0, 15));
      if4.done  = ($urandom_range(0, 3) == 0);
      if4.rr_en = 1'($urandom_range(0, 1));
      advance4();
      exp_q.push_back(exp4());
      exp = exp_q.pop_front();
      checks++;
      if ({if4.v, if4.y, if4.gnt} !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d got v/y/gnt=%b expected %b", c, {if4.v, if4.y, if4.gnt}, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_hold();
    test_round_robin();
    test_req_drop();
    test_async_reset();
    test_width();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
